// File: rtl/seq_det_pkg.sv
// Shared state type, length limits and saturating-increment helper for the
// parametrised serial sequence detector.
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } seq_state_t;

  localparam int unsigned MIN_LEN   = 2;
  localparam int unsigned MAX_LEN   = 32;
  localparam int unsigned MAX_CNT_W = 32;

  // Adds one to a cnt_w-bit value held in the low bits of cnt, sticking at all-ones.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] cnt,
                                                   input int unsigned          cnt_w);
    logic [MAX_CNT_W-1:0] top;
    top = (cnt_w >= MAX_CNT_W) ? '1 : MAX_CNT_W'((64'd1 << cnt_w) - 64'd1);
    return (cnt == top) ? cnt : cnt + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// CNT_W-wide saturating up-counter: steps on inc, holds at all-ones, never wraps.
// Synchronous active-high reset.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
    $fatal(1, "sat_counter: CNT_W=%0d outside 1..%0d", CNT_W, MAX_CNT_W);
  end

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = CNT_W'(sat_inc(MAX_CNT_W'(count_q), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial pattern detector with registered match copy and
// optional saturating match counter (built only when SEQ_DET_COUNT_EN is defined).
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  if (LEN < MIN_LEN || LEN > MAX_LEN) begin : g_bad_len
    $fatal(1, "seq_detector_param: LEN=%0d outside %0d..%0d", LEN, MIN_LEN, MAX_LEN);
  end

  localparam int unsigned    HIST_W   = LEN - 1;
  localparam int unsigned    FILL_W   = $clog2(LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

  seq_state_t          state_q;
  seq_state_t          state_d;
  logic [HIST_W-1:0]   hist_q;
  logic [HIST_W-1:0]   hist_d;
  logic [FILL_W-1:0]   fill_q;
  logic [FILL_W-1:0]   fill_d;
  logic                match_q_d;
  logic                match_c;

  // Next-state, history shift and combinational match decode.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_c   = 1'b0;
    if (!reset && en) begin
      match_c = (state_q == ARMED) && ({hist_q, in} == PATTERN);
      // Keeping the low LEN-1 bits of {hist, in} drops the oldest bit for any LEN >= 2.
      hist_d  = HIST_W'({hist_q, in});
      unique case (state_q)
        FILL: begin
          fill_d = fill_q + FILL_W'(1);
          if ((fill_q + FILL_W'(1)) == FILL_MAX) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (match_c && !OVERLAP) begin
            fill_d  = '0;
            state_d = FILL;
          end
        end
        default: begin
          fill_d  = '0;
          state_d = FILL;
        end
      endcase
    end
    match_q_d = match_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_q_d;
    end
  end

  assign match = match_c;
  assign armed = (state_q == ARMED);

`ifdef SEQ_DET_COUNT_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (match_c),
    .count (match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: four configurations share one stimulus
// stream; a reference model pushes expected per-cycle outputs, DUT outputs are popped and compared.
module tb_seq_detector_param;

  localparam int unsigned N_DUT = 4;

  typedef struct packed {
    logic       m;
    logic       mq;
    logic       arm;
    logic [7:0] cnt;
  } obs_t;

  // Configurations: default, OVERLAP=0, CNT_W=2, LEN=2 with pattern 01.
  localparam int unsigned LENS [N_DUT] = '{4, 4, 4, 2};
  localparam logic [31:0] PATS [N_DUT] = '{32'hB, 32'hB, 32'hB, 32'h1};
  localparam bit          OVLS [N_DUT] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int unsigned CMAX [N_DUT] = '{255, 255, 3, 255};
`ifdef SEQ_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             in;
  logic [N_DUT-1:0] m;
  logic [N_DUT-1:0] mq;
  logic [N_DUT-1:0] arm;
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;
  logic [1:0]       cnt2;
  logic [7:0]       cnt3;

  always #5 clk = ~clk;

  seq_detector_param u_def (
    .clk(clk), .reset(reset), .en(en), .in(in),
    .match(m[0]), .match_q(mq[0]), .match_count(cnt0), .armed(arm[0])
  );

  seq_detector_param #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .reset(reset), .en(en), .in(in),
    .match(m[1]), .match_q(mq[1]), .match_count(cnt1), .armed(arm[1])
  );

  seq_detector_param #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .en(en), .in(in),
    .match(m[2]), .match_q(mq[2]), .match_count(cnt2), .armed(arm[2])
  );

  seq_detector_param #(.LEN(2), .PATTERN(2'b01)) u_l2 (
    .clk(clk), .reset(reset), .en(en), .in(in),
    .match(m[3]), .match_q(mq[3]), .match_count(cnt3), .armed(arm[3])
  );

  // Reference model state.
  logic [31:0] sh    [N_DUT];
  int unsigned nacc  [N_DUT];
  int unsigned mcnt  [N_DUT];
  logic        mqm   [N_DUT];
  int unsigned pulses[N_DUT];

  obs_t exp_q[N_DUT][$];
  obs_t obs_q[N_DUT][$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] obs_cnt(input int i);
    case (i)
      0:       return cnt0;
      1:       return cnt1;
      2:       return {6'b0, cnt2};
      default: return cnt3;
    endcase
  endfunction

  // Drive one cycle, predict outputs, and queue expected and observed records.
  task automatic step(input logic r, input logic e, input logic b);
    logic [N_DUT-1:0] m_obs;
    logic [N_DUT-1:0] m_exp;
    @(negedge clk);
    reset = r;
    en    = e;
    in    = b;
    #1;
    m_obs = m;
    for (int i = 0; i < N_DUT; i++) begin
      logic [32:0] w;
      logic [32:0] mask;
      w        = {sh[i], b};
      mask     = (33'd1 << LENS[i]) - 33'd1;
      m_exp[i] = !r && e && (nacc[i] >= LENS[i] - 1) && ((w & mask) == {1'b0, PATS[i]});
      if (m_obs[i] === 1'b1) pulses[i]++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      obs_t x;
      obs_t o;
      if (r) begin
        sh[i]   = '0;
        nacc[i] = 0;
        mcnt[i] = 0;
        mqm[i]  = 1'b0;
      end else begin
        mqm[i] = m_exp[i];
        if (e) begin
          sh[i] = {sh[i][30:0], b};
          if (m_exp[i] && !OVLS[i]) nacc[i] = 0;
          else if (nacc[i] < LENS[i] - 1) nacc[i]++;
          if (m_exp[i] && mcnt[i] < CMAX[i]) mcnt[i]++;
        end
      end
      x.m   = m_exp[i];
      x.mq  = mqm[i];
      x.arm = (nacc[i] >= LENS[i] - 1);
      x.cnt = CNT_ON ? 8'(mcnt[i]) : 8'd0;
      o.m   = m_obs[i];
      o.mq  = mq[i];
      o.arm = arm[i];
      o.cnt = obs_cnt(i);
      exp_q[i].push_back(x);
      obs_q[i].push_back(o);
    end
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, bits[k]);
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < N_DUT; i++) pulses[i] = 0;
  endtask

  task automatic test_reset();
    obs_t x;
    obs_t o;
    clear_pulses();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < N_DUT; i++)
      while (exp_q[i].size() > 0) begin
        x = exp_q[i].pop_front();
        o = obs_q[i].pop_front();
        n_cmp++;
        if (o !== x || o !== '0) begin
          n_err++;
          $display("FAIL reset dut%0d: got m=%b mq=%b arm=%b cnt=%0d, want m=%b mq=%b arm=%b cnt=%0d",
                   i, o.m, o.mq, o.arm, o.cnt, x.m, x.mq, x.arm, x.cnt);
        end
      end
  endtask

  task automatic test_basic();
    obs_t x;
    obs_t o;
    step(1'b1, 1'b0, 1'b0);
    clear_pulses();
    feed(32'b1011, 4);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N_DUT; i++)
      while (exp_q[i].size() > 0) begin
        x = exp_q[i].pop_front();
        o = obs_q[i].pop_front();
        n_cmp++;
        if (o !== x) begin
          n_err++;
          $display("FAIL basic dut%0d: got m=%b mq=%b arm=%b cnt=%0d, want m=%b mq=%b arm=%b cnt=%0d",
                   i, o.m, o.mq, o.arm, o.cnt, x.m, x.mq, x.arm, x.cnt);
        end
      end
    n_cmp++;
    if (pulses[0] !== 1) begin
      n_err++;
      $display("FAIL basic_pulses: got %0d, want 1", pulses[0]);
    end
  endtask

  task automatic test_overlap();
    obs_t x;
    obs_t o;
    step(1'b1, 1'b0, 1'b0);
    clear_pulses();
    feed(32'b1011011, 7);
    for (int i = 0; i < N_DUT; i++)
      while (exp_q[i].size() > 0) begin
        x = exp_q[i].pop_front();
        o = obs_q[i].pop_front();
        n_cmp++;
        if (o !== x) begin
          n_err++;
          $display("FAIL overlap dut%0d: got m=%b mq=%b arm=%b cnt=%0d, want m=%b mq=%b arm=%b cnt=%0d",
                   i, o.m, o.mq, o.arm, o.cnt, x.m, x.mq, x.arm, x.cnt);
        end
      end
    n_cmp++;
    if (pulses[0] !== 2 || pulses[1] !== 1) begin
      n_err++;
      $display("FAIL overlap_pulses: got ovl=%0d novl=%0d, want ovl=2 novl=1", pulses[0], pulses[1]);
    end
  endtask

  task automatic test_enable_gap();
    obs_t x;
    obs_t o;
    step(1'b1, 1'b0, 1'b0);
    clear_pulses();
    feed(32'b10, 2);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (pulses[0] !== 0) begin
      n_err++;
      $display("FAIL gap_idle: got %0d pulses while en=0, want 0", pulses[0]);
    end
    feed(32'b11, 2);
    for (int i = 0; i < N_DUT; i++)
      while (exp_q[i].size() > 0) begin
        x = exp_q[i].pop_front();
        o = obs_q[i].pop_front();
        n_cmp++;
        if (o !== x) begin
          n_err++;
          $display("FAIL gap dut%0d: got m=%b mq=%b arm=%b cnt=%0d, want m=%b mq=%b arm=%b cnt=%0d",
                   i, o.m, o.mq, o.arm, o.cnt, x.m, x.mq, x.arm, x.cnt);
        end
      end
    n_cmp++;
    if (pulses[0] !== 1) begin
      n_err++;
      $display("FAIL gap_pulses: got %0d, want 1", pulses[0]);
    end
  endtask

  task automatic test_reset_mid();
    obs_t x;
    obs_t o;
    step(1'b1, 1'b0, 1'b0);
    clear_pulses();
    feed(32'b101, 3);
    step(1'b1, 1'b0, 1'b0);
    feed(32'b1, 1);
    n_cmp++;
    if (arm[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_armed: got %b, want 0", arm[0]);
    end
    feed(32'b01, 2);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < N_DUT; i++)
      while (exp_q[i].size() > 0) begin
        x = exp_q[i].pop_front();
        o = obs_q[i].pop_front();
        n_cmp++;
        if (o !== x) begin
          n_err++;
          $display("FAIL reset_mid dut%0d: got m=%b mq=%b arm=%b cnt=%0d, want m=%b mq=%b arm=%b cnt=%0d",
                   i, o.m, o.mq, o.arm, o.cnt, x.m, x.mq, x.arm, x.cnt);
        end
      end
    n_cmp++;
    if (pulses[0] !== 0 || cnt0 !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid_match: got pulses=%0d cnt=%0d, want 0 0", pulses[0], cnt0);
    end
  endtask

  task automatic test_saturate();
    obs_t x;
    obs_t o;
    step(1'b1, 1'b0, 1'b0);
    clear_pulses();
    repeat (5) feed(32'b1011, 4);
    for (int i = 0; i < N_DUT; i++)
      while (exp_q[i].size() > 0) begin
        x = exp_q[i].pop_front();
        o = obs_q[i].pop_front();
        n_cmp++;
        if (o !== x) begin
          n_err++;
          $display("FAIL saturate dut%0d: got m=%b mq=%b arm=%b cnt=%0d, want m=%b mq=%b arm=%b cnt=%0d",
                   i, o.m, o.mq, o.arm, o.cnt, x.m, x.mq, x.arm, x.cnt);
        end
      end
    n_cmp++;
    if (cnt2 !== (CNT_ON ? 2'd3 : 2'd0) || cnt0 !== (CNT_ON ? 8'd5 : 8'd0) || pulses[2] !== 5) begin
      n_err++;
      $display("FAIL saturate_count: got c2=%0d c8=%0d pulses=%0d, want c2=%0d c8=%0d pulses=5",
               cnt2, cnt0, pulses[2], CNT_ON ? 3 : 0, CNT_ON ? 5 : 0);
    end
  endtask

  task automatic test_random();
    obs_t x;
    obs_t o;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    for (int i = 0; i < N_DUT; i++)
      while (exp_q[i].size() > 0) begin
        x = exp_q[i].pop_front();
        o = obs_q[i].pop_front();
        n_cmp++;
        if (o !== x) begin
          n_err++;
          $display("FAIL random dut%0d: got m=%b mq=%b arm=%b cnt=%0d, want m=%b mq=%b arm=%b cnt=%0d",
                   i, o.m, o.mq, o.arm, o.cnt, x.m, x.mq, x.arm, x.cnt);
        end
      end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    in    = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      sh[i]     = '0;
      nacc[i]   = 0;
      mcnt[i]   = 0;
      mqm[i]    = 1'b0;
      pulses[i] = 0;
    end
    test_reset();
    test_basic();
    test_overlap();
    test_enable_gap();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
